// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone pipelined arbiter in front of one shared slave.
// Requests are mX.cyc. A grant is held while transfers are outstanding. A master that
// drops cyc with transfers still pending aborts them, and their late acks are discarded.
// max_outstanding bounds the number of accepted but unacknowledged strobes.
// max_burst forces re-arbitration when the other master is waiting.
// Optional feature: define WB_ARB_RR_EN to break IDLE ties round robin against the
// last-grant register. Without it, m0 always wins ties.
module wb_arb2 #(
   parameter int unsigned max_outstanding = 4,
   parameter int unsigned max_burst       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   // requester 0
   input  logic [15:0] m0_adr_i,
   input  logic [15:0] m0_dat_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   output logic [15:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_stall_o,
   // requester 1
   input  logic [15:0] m1_adr_i,
   input  logic [15:0] m1_dat_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   output logic [15:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_stall_o,
   // shared slave
   output logic [15:0] s_adr_o,
   output logic [15:0] s_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   input  logic [15:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_stall_i
);

   localparam logic [3:0]  MaxOut   = 4'(max_outstanding);
   localparam logic [15:0] MaxBurst = 16'(max_burst);

   typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

   state_e      state_q, state_d;
   logic [3:0]  out_q, out_d;
   logic [15:0] burst_q, burst_d;
   logic        last_q, last_d;   // 0: m0 granted last, 1: m1 granted last

   logic        gnt_any, sel_cyc, sel_stb, sel_we, oth_cyc;
   logic [15:0] sel_adr, sel_dat;
   logic        burst_hold, hold, abort, accept, ack_ok, pick1;

   // Select the granted master's request and derive hold/abort/accept/ack qualifiers.
   always_comb begin
      gnt_any = (state_q != StIdle);
      if (state_q == StGnt1) begin
         sel_cyc = m1_cyc_i;
         sel_stb = m1_stb_i;
         sel_we  = m1_we_i;
         sel_adr = m1_adr_i;
         sel_dat = m1_dat_i;
         oth_cyc = m0_cyc_i;
      end else begin
         sel_cyc = m0_cyc_i;
         sel_stb = m0_stb_i;
         sel_we  = m0_we_i;
         sel_adr = m0_adr_i;
         sel_dat = m0_dat_i;
         oth_cyc = m1_cyc_i;
      end
      burst_hold = (max_burst != 0) && gnt_any && oth_cyc && (burst_q >= MaxBurst);
      hold       = (out_q == MaxOut) || burst_hold;
      abort      = gnt_any && !sel_cyc && (out_q != 4'd0);
      // acks with nothing outstanding (e.g. after an abort or reset) are swallowed
      ack_ok     = gnt_any && sel_cyc && s_ack_i && (out_q != 4'd0);
   end

   // Drive the slave from the granted master; everything idle when no grant.
   always_comb begin
      s_cyc_o    = gnt_any && sel_cyc;
      s_stb_o    = gnt_any && sel_cyc && sel_stb && !hold;
      s_we_o     = gnt_any && sel_we;
      s_adr_o    = gnt_any ? sel_adr : 16'h0000;
      s_dat_o    = gnt_any ? sel_dat : 16'h0000;
      accept     = s_cyc_o && s_stb_o && !s_stall_i;
      m0_dat_o   = s_dat_i;
      m1_dat_o   = s_dat_i;
      m0_ack_o   = ack_ok && (state_q == StGnt0);
      m1_ack_o   = ack_ok && (state_q == StGnt1);
      m0_stall_o = (state_q == StGnt0) ? (s_stall_i || hold) : 1'b1;
      m1_stall_o = (state_q == StGnt1) ? (s_stall_i || hold) : 1'b1;
   end

   // Next-state: arbitration in IDLE, outstanding/burst bookkeeping and release in GNTx.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      burst_d = burst_q;
      last_d  = last_q;
      pick1   = 1'b0;
      unique case (state_q)
         StIdle: begin
            out_d   = 4'd0;
            burst_d = 16'h0000;
            if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_RR_EN
               pick1 = !last_q;
`else
               pick1 = 1'b0;
`endif
            end else begin
               pick1 = m1_cyc_i;
            end
            if (m0_cyc_i || m1_cyc_i) begin
               state_d = pick1 ? StGnt1 : StGnt0;
               last_d  = pick1;
            end
         end
         StGnt0, StGnt1: begin
            if (abort) begin
               state_d = StIdle;
               out_d   = 4'd0;
            end else begin
               if (accept && !ack_ok) begin
                  out_d = out_q + 4'd1;
               end else if (!accept && ack_ok) begin
                  out_d = out_q - 4'd1;
               end
               if (accept && (burst_q != 16'hFFFF)) begin
                  burst_d = burst_q + 16'd1;
               end
               // grant changes only with nothing in flight
               if ((out_q == 4'd0) && (!sel_cyc || burst_hold)) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset leaves last-grant on m1 so an RR tie first favours m0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         out_q   <= 4'd0;
         burst_q <= 16'h0000;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         burst_q <= burst_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: directed bench for wb_arb2 with pipelined master models, a delayed-ack slave
// model and a scoreboard of strobes that masters hand over and the slave must see.
module tb_wb_arb2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] m0_adr = '0, m0_dat_m = '0, m1_adr = '0, m1_dat_m = '0;
   logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
   logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
   logic [15:0] m0_dat_s, m1_dat_s, s_adr, s_dat_m;
   logic        m0_ack, m0_stall, m1_ack, m1_stall, s_cyc, s_stb, s_we;
   logic [15:0] s_dat_s = '0;
   logic        s_ack = 1'b0, s_stall = 1'b0;

   always #5 clk = ~clk;

   wb_arb2 #(.max_outstanding(4), .max_burst(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_m), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
      .m0_we_i(m0_we), .m0_dat_o(m0_dat_s), .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_m), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
      .m1_we_i(m1_we), .m1_dat_o(m1_dat_s), .m1_ack_o(m1_ack), .m1_stall_o(m1_stall),
      .s_adr_o(s_adr), .s_dat_o(s_dat_m), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
      .s_dat_i(s_dat_s), .s_ack_i(s_ack), .s_stall_i(s_stall)
   );

   typedef struct packed {
      logic [15:0] adr;
      logic [15:0] dat;
      logic        we;
      logic        id;
   } xfer_t;

   xfer_t m0_q[$], m1_q[$], sb_q[$];
   int    due_q[$];
   int    runs[$];
   int    n_assert = 0, n_fail = 0;
   int    cyc_cnt = 0, ack_delay = 1;
   bit    slave_stall = 1'b0, m0_kill = 1'b0, m1_kill = 1'b0, track_runs = 1'b0;
   int    m0_out = 0, m1_out = 0, m0_acc = 0, m1_acc = 0, m0_acks = 0, m1_acks = 0;
   int    max_out = 0, stall_viol = 0, cur_len = 0;
   bit    cur_id = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit id, input logic [15:0] adr, input logic [15:0] dat,
                       input bit we);
      xfer_t x;
      x = '{adr: adr, dat: dat, we: we, id: id};
      if (id) m1_q.push_back(x);
      else    m0_q.push_back(x);
   endtask

   task automatic drive_masters();
      m0_stb = 1'b0; m0_adr = '0; m0_dat_m = '0; m0_we = 1'b0;
      m1_stb = 1'b0; m1_adr = '0; m1_dat_m = '0; m1_we = 1'b0;
      if (!m0_kill && m0_q.size() > 0) begin
         m0_stb = 1'b1; m0_adr = m0_q[0].adr; m0_dat_m = m0_q[0].dat; m0_we = m0_q[0].we;
      end
      if (!m1_kill && m1_q.size() > 0) begin
         m1_stb = 1'b1; m1_adr = m1_q[0].adr; m1_dat_m = m1_q[0].dat; m1_we = m1_q[0].we;
      end
      m0_cyc = !m0_kill && (m0_q.size() > 0 || m0_out > 0);
      m1_cyc = !m1_kill && (m1_q.size() > 0 || m1_out > 0);
   endtask

   // One clock: sample at the falling edge, update models after the rising edge.
   task automatic tick();
      xfer_t e;
      bit    acc_now;
      @(negedge clk);
      acc_now = 1'b0;
      if (m0_out >= 4 && !m0_stall) stall_viol++;
      if (m1_out >= 4 && !m1_stall) stall_viol++;
      if (m0_out > max_out) max_out = m0_out;
      if (track_runs && !s_cyc && cur_len > 0) begin
         runs.push_back(cur_len);
         cur_len = 0;
      end
      if (m0_ack) begin
         chk("m0_ack_owed", 32'(m0_out > 0), 32'd1);
         chk("m0_dat_s", 32'(m0_dat_s), 32'(s_dat_s));
         m0_acks++;
         if (m0_out > 0) m0_out--;
      end
      if (m1_ack) begin
         chk("m1_ack_owed", 32'(m1_out > 0), 32'd1);
         m1_acks++;
         if (m1_out > 0) m1_out--;
      end
      if (m0_cyc && m0_stb && !m0_stall && m0_q.size() > 0) begin
         sb_q.push_back(m0_q.pop_front());
         m0_out++; m0_acc++;
      end
      if (m1_cyc && m1_stb && !m1_stall && m1_q.size() > 0) begin
         sb_q.push_back(m1_q.pop_front());
         m1_out++; m1_acc++;
      end
      if (s_cyc && s_stb && !s_stall) begin
         acc_now = 1'b1;
         chk("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("s_adr", 32'(s_adr), 32'(e.adr));
            chk("s_dat", 32'(s_dat_m), 32'(e.dat));
            chk("s_we", 32'(s_we), 32'(e.we));
            if (track_runs) begin
               if (cur_len > 0 && e.id != cur_id) begin
                  runs.push_back(cur_len);
                  cur_len = 0;
               end
               cur_id = e.id;
               cur_len++;
            end
         end
      end
      if (s_ack && due_q.size() > 0) void'(due_q.pop_front());
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (acc_now) due_q.push_back(cyc_cnt + ack_delay - 1);
      s_ack   = (due_q.size() > 0) && (due_q[0] <= cyc_cnt);
      s_stall = slave_stall;
      s_dat_s = 16'(cyc_cnt * 3);
      drive_masters();
      #2;
   endtask

   task automatic drain(input int bound);
      bit done;
      done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         tick();
         done = (m0_q.size() == 0) && (m1_q.size() == 0) && (m0_out == 0) && (m1_out == 0)
                && (due_q.size() == 0) && !s_cyc;
      end
      chk("drain_done", 32'(done), 32'd1);
      tick();
   endtask

   task automatic clear_models();
      m0_q.delete(); m1_q.delete(); sb_q.delete(); due_q.delete();
      m0_out = 0; m1_out = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          a0, a1, base, idle_c, gnt_c, viol;
      int          exp_runs[$];

      // reset state with live-looking inputs
      push(1'b0, 16'h0abc, 16'h1234, 1'b1);
      drive_masters();
      s_ack = 1'b1;
      #3;
      chk("rst_s_cyc", 32'(s_cyc), 32'd0);
      chk("rst_s_stb", 32'(s_stb), 32'd0);
      chk("rst_s_we", 32'(s_we), 32'd0);
      chk("rst_m0_ack", 32'(m0_ack), 32'd0);
      chk("rst_m0_stall", 32'(m0_stall), 32'd1);
      chk("rst_m1_stall", 32'(m1_stall), 32'd1);
      clear_models();
      drive_masters();
      s_ack = 1'b0;
      #7 rst_n = 1'b1;
      tick();

      // single read from m0
      push(1'b0, 16'h0010, 16'h0000, 1'b0);
      tick();
      chk("a_idle_m0_stall", 32'(m0_stall), 32'd1);
      chk("a_idle_s_cyc", 32'(s_cyc), 32'd0);
      tick();
      chk("a_gnt_s_cyc", 32'(s_cyc), 32'd1);
      chk("a_gnt_s_stb", 32'(s_stb), 32'd1);
      chk("a_gnt_s_adr", 32'(s_adr), 32'h0010);
      chk("a_gnt_m0_stall", 32'(m0_stall), 32'd0);
      chk("a_gnt_m1_stall", 32'(m1_stall), 32'd1);
      tick();
      chk("a_m0_ack", 32'(m0_ack), 32'd1);
      chk("a_m1_ack", 32'(m1_ack), 32'd0);
      tick();
      chk("a_drop_s_cyc", 32'(s_cyc), 32'd0);
      tick();
      chk("a_idle_again", 32'(m0_stall), 32'd1);

      // simultaneous requests straight after reset: m0 wins
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a0 = m0_acks; a1 = m1_acks;
      push(1'b0, 16'h0100, 16'hA001, 1'b1);
      push(1'b0, 16'h0101, 16'hA002, 1'b1);
      push(1'b1, 16'h0200, 16'hB001, 1'b1);
      tick();
      chk("b_idle_m0_stall", 32'(m0_stall), 32'd1);
      chk("b_idle_m1_stall", 32'(m1_stall), 32'd1);
      tick();
      chk("b_gnt0_m0_stall", 32'(m0_stall), 32'd0);
      chk("b_gnt0_m1_stall", 32'(m1_stall), 32'd1);
      idle_c = 0; gnt_c = 0; viol = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!s_cyc) idle_c = cyc_cnt;
         if (m1_cyc && !m1_stall) begin
            gnt_c = cyc_cnt;
            break;
         end
         if (m0_cyc && !m1_stall) viol++;
      end
      chk("b_m1_granted", 32'(gnt_c != 0), 32'd1);
      chk("b_m1_latency", 32'(gnt_c - idle_c), 32'd1);
      chk("b_m1_stalled", 32'(viol), 32'd0);
      drain(40);
      chk("b_m0_acks", 32'(m0_acks - a0), 32'd2);
      chk("b_m1_acks", 32'(m1_acks - a1), 32'd1);

      // outstanding limit with slow acks
      ack_delay = 6; max_out = 0; stall_viol = 0;
      a0 = m0_acks; base = m0_acc;
      for (int i = 0; i < 8; i++) push(1'b0, 16'(16'h0300 + i), 16'(16'hC000 + i), 1'b1);
      drain(200);
      chk("c_max_outstanding", 32'(max_out), 32'd4);
      chk("c_stall_at_limit", 32'(stall_viol), 32'd0);
      chk("c_accepts", 32'(m0_acc - base), 32'd8);
      chk("c_acks", 32'(m0_acks - a0), 32'd8);
      chk("c_sb_empty", 32'(sb_q.size()), 32'd0);

      // m1 aborts with two transfers outstanding
      base = m1_acc;
      for (int i = 0; i < 4; i++) push(1'b1, 16'(16'h0400 + i), 16'(16'hD000 + i), 1'b1);
      for (int i = 0; i < 20 && (m1_acc - base) < 2; i++) tick();
      chk("d_two_accepted", 32'(m1_acc - base), 32'd2);
      a0 = m0_acks; a1 = m1_acks;
      m1_kill = 1'b1;
      m1_q.delete();
      m1_out = 0;
      drive_masters();
      #1;
      chk("d_abort_s_cyc", 32'(s_cyc), 32'd0);
      tick();
      chk("d_idle_s_cyc", 32'(s_cyc), 32'd0);
      chk("d_idle_m1_stall", 32'(m1_stall), 32'd1);
      for (int i = 0; i < 12; i++) tick();
      chk("d_no_m0_acks", 32'(m0_acks - a0), 32'd0);
      chk("d_no_m1_acks", 32'(m1_acks - a1), 32'd0);
      chk("d_late_acks_sent", 32'(due_q.size()), 32'd0);
      m1_kill = 1'b0;

      // burst fairness with both masters streaming
      ack_delay = 1;
      runs.delete(); cur_len = 0; track_runs = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push(1'b0, 16'(16'h0500 + i), 16'(16'hE000 + i), 1'b1);
         push(1'b1, 16'(16'h0600 + i), 16'(16'hF000 + i), 1'b0);
      end
      drain(400);
      if (cur_len > 0) runs.push_back(cur_len);
      track_runs = 1'b0;
`ifdef WB_ARB_RR_EN
      exp_runs = '{16, 16, 4, 4};
`else
      exp_runs = '{16, 4, 20};
`endif
      chk("e_run_count", 32'(runs.size()), 32'(exp_runs.size()));
      for (int i = 0; i < exp_runs.size(); i++) begin
         chk($sformatf("e_run%0d", i), (i < runs.size()) ? 32'(runs[i]) : 32'hFFFFFFFF,
             32'(exp_runs[i]));
      end

      // asynchronous reset in the middle of a burst
      ack_delay = 3;
      base = m0_acc;
      for (int i = 0; i < 6; i++) push(1'b0, 16'(16'h0700 + i), 16'(16'h7000 + i), 1'b1);
      for (int i = 0; i < 20 && (m0_acc - base) < 2; i++) tick();
      rst_n = 1'b0;
      s_ack = 1'b1;
      #1;
      chk("f_rst_s_cyc", 32'(s_cyc), 32'd0);
      chk("f_rst_s_stb", 32'(s_stb), 32'd0);
      chk("f_rst_s_we", 32'(s_we), 32'd0);
      chk("f_rst_m0_ack", 32'(m0_ack), 32'd0);
      chk("f_rst_m1_ack", 32'(m1_ack), 32'd0);
      chk("f_rst_m0_stall", 32'(m0_stall), 32'd1);
      chk("f_rst_m1_stall", 32'(m1_stall), 32'd1);
      clear_models();
      s_ack = 1'b0;
      drive_masters();
      tick();
      tick();
      rst_n = 1'b1;
      ack_delay = 1;
      a0 = m0_acks; a1 = m1_acks;
      push(1'b0, 16'h0800, 16'h8000, 1'b0);
      push(1'b1, 16'h0900, 16'h9000, 1'b0);
      tick();
      tick();
      chk("f_tie_m0_stall", 32'(m0_stall), 32'd0);
      chk("f_tie_m1_stall", 32'(m1_stall), 32'd1);
      chk("f_tie_s_adr", 32'(s_adr), 32'h0800);
      drain(60);
      chk("f_m0_acks", 32'(m0_acks - a0), 32'd1);
      chk("f_m1_acks", 32'(m1_acks - a1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
